serial_mag_comp: RTL and testbench



---
 rtl/serial_mag_comp.sv | 101 ++++++++++
 tb/tb_serial_mag_comp.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comp.sv
// Bit-serial MSB-first magnitude comparator with a start/busy/done handshake.
// Define SERIAL_COMP_EARLY_EXIT_EN to end SHIFT at the first differing bit.
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             bit_x,
  output logic             bit_y
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa, r_sb;
  logic [IW-1:0]    r_idx;
  logic             r_busy, r_done, r_eq, r_gt, r_lt;

  logic w_x, w_y, w_diff, w_seen, w_first, w_end;

  assign w_x     = r_sa[r_idx];
  assign w_y     = r_sb[r_idx];
  assign w_diff  = w_x ^ w_y;
  assign w_seen  = r_gt | r_lt;
  // Only the most significant difference may set the verdict.
  assign w_first = w_diff & ~w_seen;

`ifdef SERIAL_COMP_EARLY_EXIT_EN
  assign w_end = (r_idx == '0) | w_first;
`else
  assign w_end = (r_idx == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_idx   <= IDX_TOP;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_first) begin
            r_gt <= w_x;
            r_lt <= w_y;
          end
          if (w_end) begin
            r_eq    <= ~(w_seen | w_diff);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign eq    = r_eq;
  assign gt    = r_gt;
  assign lt    = r_lt;
  assign bit_x = w_x;
  assign bit_y = w_y;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Scoreboard bench for serial_mag_comp: stimulus pushes expected verdicts,
// a negedge monitor pops and compares them whenever done is seen.
module tb_serial_mag_comp;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             busy, done, eq, gt, lt, bit_x, bit_y;

  serial_mag_comp #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt),
    .bit_x(bit_x), .bit_y(bit_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         acc;
    int         lat;
    logic [2:0] v;   // {eq,gt,lt}
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   busy_cnt;
  logic [WIDTH-1:0] seq_x, seq_y;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp_v);
    nchk++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Latency for a pair whose most significant differing bit is msb (-1 = equal)
  function automatic int exp_lat(input int msb);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    return (msb < 0) ? WIDTH : WIDTH - msb;
`else
    return WIDTH;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("verdict", int'({eq, gt, lt}), int'(e.v));
        check("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while ((busy || done) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) check("idle_timeout", 1, 0);
  endtask

  // Issue one accepted compare, then follow it to done collecting busy/bits.
  task automatic run(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                     input logic [2:0] v, input int msb, input bit push);
    exp_t e;
    int n = 0;
    wait_idle();
    start = 1'b1; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0;
    e.acc = cyc; e.lat = exp_lat(msb); e.v = v;
    if (push) q.push_back(e);
    busy_cnt = 0; seq_x = '0; seq_y = '0;
    @(negedge clk);
    while (!done && n < 40) begin
      if (busy) begin
        busy_cnt++;
        seq_x = {seq_x[WIDTH-2:0], bit_x};
        seq_y = {seq_y[WIDTH-2:0], bit_y};
      end
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("done_timeout", 1, 0);
  endtask

  initial begin
    int n;
    exp_t e;
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_outs", int'({done, eq, gt, lt, bit_x, bit_y}), 0);
    #20 rst_n = 1'b1;

    run(8'hA5, 8'hA5, 3'b100, -1, 1);
    check("A5_busy_cycles", busy_cnt, 8);

    run(8'h80, 8'h7F, 3'b010, 7, 1);

    run(8'h12, 8'h13, 3'b001, 0, 1);
`ifndef SERIAL_COMP_EARLY_EXIT_EN
    check("bitseq_x", int'(seq_x), 8'h12);
    check("bitseq_y", int'(seq_y), 8'h13);
`else
    check("bitseq_x", int'(seq_x), 8'h12);
    check("bitseq_y", int'(seq_y), 8'h13);
`endif

    // Second start during SHIFT must be ignored
    wait_idle();
    start = 1'b1; a = 8'h01; b = 8'h02;
    @(posedge clk); #1;
    start = 1'b0;
    e.acc = cyc; e.lat = exp_lat(1); e.v = 3'b001;
    q.push_back(e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; a = 8'hFF; b = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1 check("ignored_start_busy", int'(busy), 0);

    // Reset three edges into a compare: everything clears, no done
    wait_idle();
    start = 1'b1; a = 8'h55; b = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs", int'({busy, done, eq, gt, lt}), 0);
    check("async_rst_bits", int'({bit_x, bit_y}), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (WIDTH + 2) @(posedge clk);
    #1 check("no_done_after_abort", q.size(), 0);

    run(8'h40, 8'h20, 3'b010, 6, 1);

    // start held high: back-to-back compares every WIDTH+2 cycles
    wait_idle();
    start = 1'b1; a = 8'h3C; b = 8'h3C;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      e.acc = cyc + k * (WIDTH + 2); e.lat = WIDTH; e.v = 3'b100;
      q.push_back(e);
    end
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("held_start_drain", q.size(), 0);
    repeat (WIDTH + 4) @(posedge clk);
    #1 check("no_extra_done", int'(busy), 0);
    check("final_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
